// File: rtl/char_flush_scanner.sv
// rtl/char_flush_scanner.sv - sweeps a glyph cell and emits one VGA plot per lit pixel.
// Optional build macro CHAR_FLUSH_BG_FILL_EN: unlit pixels are plotted in bg_colour.
module char_flush_scanner #(
  parameter int CELL_W  = 10,
  parameter int CELL_H  = 10,
  parameter int COORD_W = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [COORD_W-1:0] org_x,
  input  logic [COORD_W-1:0] org_y,
  output logic               busy,
  output logic               done,
  output logic [COORD_W-1:0] flush_x,
  output logic [COORD_W-1:0] flush_y,
  input  logic               glyph_en,
  input  logic [5:0]         glyph_colour,
`ifdef CHAR_FLUSH_BG_FILL_EN
  input  logic [5:0]         bg_colour,
`endif
  output logic               plot,
  input  logic               plot_ready,
  output logic [COORD_W-1:0] vga_x,
  output logic [COORD_W-1:0] vga_y,
  output logic [5:0]         vga_colour
);

  localparam int COL_W = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int ROW_W = (CELL_H > 1) ? $clog2(CELL_H) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  logic [COORD_W-1:0] r_org_x;
  logic [COORD_W-1:0] r_org_y;
  logic               r_plot;
  logic [COORD_W-1:0] r_vga_x;
  logic [COORD_W-1:0] r_vga_y;
  logic [5:0]         r_vga_colour;

  logic               w_free;
  logic               w_last_col;
  logic               w_last_row;
  logic               w_accept;
  logic               w_sample;
  logic               w_drain;
  logic               w_pix_plot;
  logic [5:0]         w_pix_colour;

  // The output register may only be reloaded once the pending plot is taken.
  assign w_free     = !r_plot || plot_ready;
  assign w_last_col = (r_col == COL_W'(CELL_W - 1));
  assign w_last_row = (r_row == ROW_W'(CELL_H - 1));

  assign flush_x = r_org_x + COORD_W'(r_col);
  assign flush_y = r_org_y + COORD_W'(r_row);

`ifdef CHAR_FLUSH_BG_FILL_EN
  assign w_pix_plot   = 1'b1;
  assign w_pix_colour = glyph_en ? glyph_colour : bg_colour;
`else
  assign w_pix_plot   = glyph_en;
  assign w_pix_colour = glyph_colour;
`endif

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_sample     = 1'b0;
    w_drain      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_free) begin
          w_sample = 1'b1;
          if (w_last_col && w_last_row) begin
            w_next_state = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_free) begin
          w_drain      = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_col        <= '0;
      r_row        <= '0;
      r_org_x      <= '0;
      r_org_y      <= '0;
      r_plot       <= 1'b0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
    end else begin
      if (w_accept) begin
        r_org_x <= org_x;
        r_org_y <= org_y;
        r_col   <= '0;
        r_row   <= '0;
      end
      if (w_sample) begin
        r_plot       <= w_pix_plot;
        r_vga_x      <= flush_x;
        r_vga_y      <= flush_y;
        r_vga_colour <= w_pix_colour;
        // Raster order: column fastest; row returns to 0 after the final sample.
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
      if (w_drain) begin
        r_plot <= 1'b0;
      end
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign plot       = r_plot;
  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;

endmodule

// File: tb/tb_char_flush_scanner.sv
// tb/tb_char_flush_scanner.sv - directed self-checking bench for char_flush_scanner.
// Honours CHAR_FLUSH_BG_FILL_EN when the design is built with it.
module tb_char_flush_scanner;

`ifdef CHAR_FLUSH_BG_FILL_EN
  localparam int   EXP_N     = 100;
  localparam int   EXP_BG    = 76;
  localparam logic [7:0] FIRST_C = 8'd0;
  localparam logic [7:0] LAST_C  = 8'd9;
`else
  localparam int   EXP_N     = 24;
  localparam int   EXP_BG    = 0;
  localparam logic [7:0] FIRST_C = 8'd2;
  localparam logic [7:0] LAST_C  = 8'd7;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [7:0] org_x;
  logic [7:0] org_y;
  logic       busy;
  logic       done;
  logic [7:0] flush_x;
  logic [7:0] flush_y;
  logic       glyph_en;
  logic [5:0] glyph_colour;
  logic       plot;
  logic       plot_ready;
  logic [7:0] vga_x;
  logic [7:0] vga_y;
  logic [5:0] vga_colour;
`ifdef CHAR_FLUSH_BG_FILL_EN
  logic [5:0] bg_colour = 6'h05;
`endif

  char_flush_scanner #(.CELL_W(10), .CELL_H(10), .COORD_W(8)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .org_x        (org_x),
    .org_y        (org_y),
    .busy         (busy),
    .done         (done),
    .flush_x      (flush_x),
    .flush_y      (flush_y),
    .glyph_en     (glyph_en),
    .glyph_colour (glyph_colour),
`ifdef CHAR_FLUSH_BG_FILL_EN
    .bg_colour    (bg_colour),
`endif
    .plot         (plot),
    .plot_ready   (plot_ready),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_colour   (vga_colour)
  );

  always #5 clk = ~clk;

  // "X" glyph: 24 lit pixels, first at col 2 row 0, last at col 7 row 9.
  function automatic logic lit_at(input logic [7:0] c, input logic [7:0] r);
    logic [9:0] m;
    case (r)
      8'd0, 8'd9:             m = 10'h084;
      8'd1, 8'd8:             m = 10'h0CC;
      8'd2, 8'd7:             m = 10'h048;
      8'd3, 8'd4, 8'd5, 8'd6: m = 10'h030;
      default:                m = 10'h000;
    endcase
    return (c < 8'd10) ? m[c[3:0]] : 1'b0;
  endfunction

  function automatic logic [5:0] col6(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] s;
    s = x + {y[6:0], 1'b0};
    return s[5:0];
  endfunction

  logic [7:0] tb_ox = 8'd0;
  logic [7:0] tb_oy = 8'd0;
  logic [7:0] rel_fx, rel_fy, rel_vx, rel_vy;
  assign rel_fx       = flush_x - tb_ox;
  assign rel_fy       = flush_y - tb_oy;
  assign rel_vx       = vga_x - tb_ox;
  assign rel_vy       = vga_y - tb_oy;
  assign glyph_en     = lit_at(rel_fx, rel_fy);
  assign glyph_colour = col6(flush_x, flush_y);

  logic       mon_lit;
  logic [5:0] mon_exp_col;
  logic       mon_ok;
  assign mon_lit = lit_at(rel_vx, rel_vy);
`ifdef CHAR_FLUSH_BG_FILL_EN
  assign mon_exp_col = mon_lit ? col6(vga_x, vga_y) : 6'h05;
  assign mon_ok      = 1'b1;
`else
  assign mon_exp_col = col6(vga_x, vga_y);
  assign mon_ok      = mon_lit;
`endif

  int         n_plots   = 0;
  int         n_done    = 0;
  int         n_col_err = 0;
  int         n_unlit   = 0;
  logic [7:0] px [0:1023];
  logic [7:0] py [0:1023];

  always @(negedge clk) begin
    if (resetn) begin
      if (done) n_done <= n_done + 1;
      if (plot && plot_ready) begin
        if (n_plots < 1024) begin
          px[n_plots] <= vga_x;
          py[n_plots] <= vga_y;
        end
        n_plots <= n_plots + 1;
        if (!mon_lit) n_unlit <= n_unlit + 1;
        if (vga_colour !== mon_exp_col || !mon_ok) n_col_err <= n_col_err + 1;
      end
    end
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_cell(input logic [7:0] ox, input logic [7:0] oy);
    org_x = ox;
    org_y = oy;
    tb_ox = ox;
    tb_oy = oy;
    start = 1'b1;
    cyc   = 1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    while (done !== 1'b1 && cyc < 400) tick();
  endtask

  task automatic check_cell(input string tag, input int p0, input int u0, input int e0,
                            input logic [7:0] ox, input logic [7:0] oy);
    chk({tag, "_nplots"}, n_plots - p0, EXP_N);
    chk({tag, "_first_x"}, {24'd0, px[p0]}, {24'd0, 8'(ox + FIRST_C)});
    chk({tag, "_first_y"}, {24'd0, py[p0]}, {24'd0, oy});
    chk({tag, "_last_x"}, {24'd0, px[n_plots-1]}, {24'd0, 8'(ox + LAST_C)});
    chk({tag, "_last_y"}, {24'd0, py[n_plots-1]}, {24'd0, 8'(oy + 8'd9)});
    chk({tag, "_colour_err"}, n_col_err - e0, 0);
    chk({tag, "_bg_plots"}, n_unlit - u0, EXP_BG);
  endtask

  int         p0, u0, e0, d0, k, hold_bad;
  logic [7:0] sx, sy, sfx, sfy;
  logic [5:0] scol;
  logic [7:0] fxs [0:9];

  initial begin
    resetn     = 1'b0;
    start      = 1'b0;
    org_x      = 8'd0;
    org_y      = 8'd0;
    plot_ready = 1'b1;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_plot", plot, 0);
    chk("rst_vga", {vga_x, vga_y, vga_colour}, 0);
    chk("rst_flush", {flush_x, flush_y}, 0);
    resetn = 1'b1;
    tick();

    // Basic cell at (20,30), plot_ready tied high.
    p0 = n_plots; u0 = n_unlit; e0 = n_col_err;
    start_cell(8'd20, 8'd30);
    chk("a_busy_rise", busy, 1);
    chk("a_flush0", {flush_x, flush_y}, {8'd20, 8'd30});
    wait_done();
    chk("a_done", done, 1);
    chk("a_done_cycle", cyc, 103);
    tick();
    chk("a_busy_fall", busy, 0);
    chk("a_done_fall", done, 0);
    check_cell("a", p0, u0, e0, 8'd20, 8'd30);

    // Backpressure on the first plot.
    p0 = n_plots; u0 = n_unlit; e0 = n_col_err;
    plot_ready = 1'b0;
    start_cell(8'd20, 8'd30);
    k = 0;
    while (plot !== 1'b1 && k < 50) begin tick(); k++; end
    chk("b_plot_seen", plot, 1);
    chk("b_first_vga_x", vga_x, 8'(8'd20 + FIRST_C));
    sx = vga_x; sy = vga_y; scol = vga_colour; sfx = flush_x; sfy = flush_y;
    chk("b_frozen_fx", sfx, 8'(8'd21 + FIRST_C));
    chk("b_frozen_fy", sfy, 8'd30);
    hold_bad = 0;
    repeat (5) begin
      tick();
      if ({vga_x, vga_y, vga_colour, flush_x, flush_y, plot} !== {sx, sy, scol, sfx, sfy, 1'b1})
        hold_bad++;
    end
    chk("b_hold_stable", hold_bad, 0);
    plot_ready = 1'b1;
    wait_done();
    chk("b_done", done, 1);
    tick();
    check_cell("b", p0, u0, e0, 8'd20, 8'd30);

    // Coordinate wrap at (250,250).
    p0 = n_plots; u0 = n_unlit; e0 = n_col_err;
    start_cell(8'd250, 8'd250);
    for (int i = 0; i < 10; i++) begin
      fxs[i] = flush_x;
      tick();
    end
    chk("c_fx0", fxs[0], 8'd250);
    chk("c_fx5", fxs[5], 8'd255);
    chk("c_fx6", fxs[6], 8'd0);
    chk("c_fx9", fxs[9], 8'd3);
    chk("c_row1_fy", flush_y, 8'd251);
    wait_done();
    chk("c_done", done, 1);
    chk("c_done_cycle", cyc, 103);
    tick();
    check_cell("c", p0, u0, e0, 8'd250, 8'd250);

    // start pulses and origin changes while busy are ignored.
    p0 = n_plots; u0 = n_unlit; e0 = n_col_err; d0 = n_done;
    start_cell(8'd40, 8'd50);
    repeat (10) tick();
    org_x = 8'd0;
    org_y = 8'd0;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    wait_done();
    chk("d_done_cycle", cyc, 103);
    tick();
    check_cell("d", p0, u0, e0, 8'd40, 8'd50);
    chk("d_one_done", n_done - d0, 1);

    // Second start after done draws a new cell.
    p0 = n_plots; u0 = n_unlit; e0 = n_col_err;
    start_cell(8'd100, 8'd100);
    wait_done();
    chk("d2_done_cycle", cyc, 103);
    tick();
    check_cell("d2", p0, u0, e0, 8'd100, 8'd100);

    // Reset mid-scan abandons the cell without a done pulse.
    d0 = n_done;
    start_cell(8'd60, 8'd60);
    repeat (20) tick();
    resetn = 1'b0;
    #1;
    chk("e_rst_busy_done_plot", {busy, done, plot}, 0);
    chk("e_rst_vga", {vga_x, vga_y, vga_colour}, 0);
    chk("e_rst_flush", {flush_x, flush_y}, 0);
    tick();
    resetn = 1'b1;
    repeat (120) tick();
    chk("e_no_done", n_done - d0, 0);
    chk("e_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
